dualport_ram_reader: RTL and testbench

- Burst read engine on the read-only port 1 of the team's dualport_ram.
- On a start command it walks a contiguous address range (start address + length, wrapping at depth) and drives the RAM address and port enable.
- Each combinationally-read word is captured into a registered output stage and presented on a valid/ready stream to downstream logic.
- Writes continue independently on RAM port 0.

---
 rtl/dualport_ram_reader.sv | 61 ++++++
 tb/tb_dualport_ram_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dualport_ram_reader.sv
// dualport_ram_reader: burst reader on dualport_ram port 1 feeding a registered valid/ready stream
module dualport_ram_reader #(
  parameter int data_width = 8,
  parameter int addr_width = 4,
  parameter int depth = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] start_addr,
  input  logic [addr_width:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] ram_addr,
  output logic                  ram_en,
  input  logic [data_width-1:0] ram_data,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
  localparam logic [addr_width:0] depth_c = (addr_width+1)'(depth);
  localparam logic [addr_width-1:0] last_addr = addr_width'(depth - 1);
  state_t state;
  logic [addr_width-1:0] addr;
  logic [addr_width:0] remaining, clamped;
  logic load, take;
  assign clamped = length > depth_c ? depth_c : length;
  assign take = m_valid & m_ready;
  assign load = state == READ && (!m_valid || m_ready);
  assign busy = state == READ || state == DRAIN;
  assign done = state == FIN;
  assign ram_en = state == READ;
  assign ram_addr = addr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      m_data <= '0;
      m_valid <= 1'b0;
    end else begin
      if (load) begin
        m_data <= ram_data;
        m_valid <= 1'b1;
        addr <= addr == last_addr ? '0 : addr + addr_width'(1);
        remaining <= remaining - (addr_width+1)'(1);
      end else if (take)
        m_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          addr <= start_addr;
          remaining <= clamped;
          state <= clamped == '0 ? FIN : READ;
        end
        READ: if (load && remaining == (addr_width+1)'(1)) state <= DRAIN;
        DRAIN: if (take) state <= FIN;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dualport_ram_reader.sv
// tb_dualport_ram_reader: randomized burst scenarios checked against a queue-based reference model
module tb_dualport_ram_reader;
  logic clk = 0, rst = 1, start = 0, m_ready = 0;
  logic [3:0] start_addr = 0, ram_addr;
  logic [4:0] length = 0;
  logic busy, done, ram_en, m_valid;
  logic [7:0] ram_data, m_data;
  logic [7:0] mem [16];
  int n_cmp = 0, n_err = 0;
  logic [7:0] got [$], exp [$];
  logic [3:0] got_addr [$], exp_addr [$];
  int got_cyc [$], done_cyc [$];
  int unstable, en_after, timeout;

  dualport_ram_reader #(.data_width(8), .addr_width(4), .depth(16)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_en(ram_en), .ram_data(ram_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;
  assign ram_data = mem[ram_addr];

  // Reference: a burst reads min(len,16) consecutive words modulo 16
  task automatic model(input int sa, input int len);
    exp.delete();
    exp_addr.delete();
    for (int i = 0; i < (len > 16 ? 16 : len); i++) begin
      exp.push_back(mem[(sa + i) % 16]);
      exp_addr.push_back(4'((sa + i) % 16));
    end
  endtask

  task automatic launch(input logic [3:0] sa, input logic [4:0] len);
    @(negedge clk);
    start = 1;
    start_addr = sa;
    length = len;
    @(negedge clk);
    start = 0;
  endtask

  // rmode: 0 ready high, 1 pattern 1,0,0,1,1.., 2 random; observes until two cycles past done
  task automatic collect(input int rmode, input bit poke);
    logic [7:0] prev_d = 0;
    bit prev_stall = 0;
    int first_done = -1;
    got.delete(); got_addr.delete(); got_cyc.delete(); done_cyc.delete();
    unstable = 0; en_after = 0; timeout = 1;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) @(negedge clk);
      m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? !(c == 1 || c == 2) : 1'($urandom_range(0, 1));
      if (poke) begin
        start = c == 2;
        if (c == 2) begin start_addr = 4'd9; length = 5'd1; end
      end
      #1;
      if (prev_stall && (!m_valid || m_data !== prev_d)) unstable++;
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      if (first_done >= 0 && (ram_en || m_valid || busy)) en_after++;
      if (ram_en && (!m_valid || m_ready)) got_addr.push_back(ram_addr);
      if (m_valid && m_ready) begin got.push_back(m_data); got_cyc.push_back(c); end
      if (done) begin done_cyc.push_back(c); if (first_done < 0) first_done = c; end
      if (first_done >= 0 && c == first_done + 2) begin timeout = 0; break; end
    end
    start = 0;
    m_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, ram_en, m_valid, ram_addr, m_data} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs got busy=%b done=%b en=%b valid=%b addr=%h data=%h want all 0", busy, done, ram_en, m_valid, ram_addr, m_data);
    end
    rst = 0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
    model(3, 4);
    launch(3, 4);
    collect(0, 0);
    n_cmp++;
    if (timeout) begin n_err++; $display("FAIL basic_timeout got no done want done"); end
    n_cmp++;
    if (got.size() != 4) begin n_err++; $display("FAIL basic_count got %0d want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_cmp++;
      if (got[i] !== exp[i] || got_cyc[i] != 1 + i) begin
        n_err++;
        $display("FAIL basic_word%0d got %h@%0d want %h@%0d", i, got[i], got_cyc[i], exp[i], 1 + i);
      end
    end
    n_cmp++;
    if (done_cyc.size() != 1 || done_cyc[0] != 5) begin
      n_err++;
      $display("FAIL basic_done got %0d pulses first@%0d want 1@5", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
    end
    n_cmp++;
    if (en_after != 0) begin n_err++; $display("FAIL basic_idle_after got %0d active cycles want 0", en_after); end
  endtask

  task automatic test_wrap();
    model(14, 4);
    launch(14, 4);
    collect(0, 0);
    n_cmp++;
    if (got != exp) begin n_err++; $display("FAIL wrap_words got %p want %p", got, exp); end
    n_cmp++;
    if (got_addr != exp_addr) begin n_err++; $display("FAIL wrap_addrs got %p want %p", got_addr, exp_addr); end
    n_cmp++;
    if (timeout || done_cyc.size() != 1) begin n_err++; $display("FAIL wrap_done got %0d pulses want 1", done_cyc.size()); end
  endtask

  task automatic test_backpressure();
    model(8, 3);
    launch(8, 3);
    collect(1, 0);
    n_cmp++;
    if (got != exp) begin n_err++; $display("FAIL bp_words got %p want %p", got, exp); end
    n_cmp++;
    if (unstable != 0) begin n_err++; $display("FAIL bp_stable got %0d changes while stalled want 0", unstable); end
    n_cmp++;
    if (timeout || done_cyc.size() != 1 || got_cyc.size() == 0 || done_cyc[0] != got_cyc[$] + 1) begin
      n_err++;
      $display("FAIL bp_done got %0d pulses first@%0d want 1 pulse after last handshake", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
    end
  endtask

  task automatic test_lengths();
    launch(5, 0);
    collect(0, 0);
    n_cmp++;
    if (got.size() != 0 || got_addr.size() != 0 || done_cyc.size() != 1 || done_cyc[0] != 0 || timeout) begin
      n_err++;
      $display("FAIL len0 got %0d words %0d loads %0d dones want 0 0 1", got.size(), got_addr.size(), done_cyc.size());
    end
    model(6, 20);
    launch(6, 20);
    collect(0, 0);
    n_cmp++;
    if (got != exp || got.size() != 16) begin n_err++; $display("FAIL len20 got %0d words want 16 matching model", got.size()); end
    n_cmp++;
    if (timeout || done_cyc.size() != 1 || done_cyc[0] != got_cyc[$] + 1) begin n_err++; $display("FAIL len20_done got %0d pulses want 1", done_cyc.size()); end
  endtask

  task automatic test_start_while_busy();
    model(2, 5);
    launch(2, 5);
    collect(0, 1);
    n_cmp++;
    if (got != exp || got_addr != exp_addr) begin n_err++; $display("FAIL busy_start got %p want %p", got, exp); end
    n_cmp++;
    if (timeout || done_cyc.size() != 1 || en_after != 0) begin
      n_err++;
      $display("FAIL busy_start_done got %0d pulses %0d active after want 1 0", done_cyc.size(), en_after);
    end
  endtask

  task automatic test_async_reset();
    int bad = 0;
    launch(0, 8);
    m_ready = 0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL arst_pre got valid=%b busy=%b want 1 1", m_valid, busy); end
    #1 rst = 1;
    #1;
    n_cmp++;
    if ({m_valid, busy, ram_en, done} !== 4'b0) begin
      n_err++;
      $display("FAIL arst_immediate got valid=%b busy=%b en=%b done=%b want 0", m_valid, busy, ram_en, done);
    end
    @(negedge clk);
    rst = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (done || m_valid || busy) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL arst_quiet got %0d active cycles want 0", bad); end
    model(5, 3);
    launch(5, 3);
    collect(0, 0);
    n_cmp++;
    if (got != exp || timeout || done_cyc.size() != 1) begin n_err++; $display("FAIL arst_restart got %p want %p", got, exp); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int sa = $urandom_range(0, 15), len = $urandom_range(0, 20);
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      model(sa, len);
      launch(4'(sa), 5'(len));
      collect(2, 0);
      n_cmp++;
      if (got != exp || got_addr != exp_addr || unstable != 0) begin
        n_err++;
        $display("FAIL rand%0d sa=%0d len=%0d got %p want %p unstable=%0d", t, sa, len, got, exp, unstable);
      end
      n_cmp++;
      if (timeout || done_cyc.size() != 1 || done_cyc[0] != (got_cyc.size() ? got_cyc[$] + 1 : 0)) begin
        n_err++;
        $display("FAIL rand%0d_done got %0d pulses first@%0d", t, done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_lengths();
    test_start_while_busy();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
